// File: rtl/freq_counter_pkg.sv
// Shared constants, FSM encoding and BCD helper for the edge train generator.
package freq_counter_pkg;

  localparam int unsigned UPDATE_PERIOD = 1200;
  localparam int unsigned BITS          = 12;
  localparam int unsigned CNT_W         = BITS + 1;
  localparam int unsigned MAX_COUNT     = 99;
  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned N_W           = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    CALC    = 2'd2,
    RUN     = 2'd3
  } state_e;

  // Clamp a BCD digit to 9.
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
  endfunction

endpackage

// File: rtl/rep_sub_divider.sv
// Unsigned divider by repeated subtraction: one subtraction per cycle, done pulses once.
module rep_sub_divider
  import freq_counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [CNT_W-1:0] quotient
);

  logic             active_q, active_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] quo_q, quo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  // A zero divisor terminates immediately with quotient 0.
  always_comb begin
    active_d = active_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    quo_d    = quo_q;
    if (start) begin
      active_d = 1'b1;
      rem_d    = dividend;
      quo_d    = '0;
    end else if (active_q) begin
      if ((divisor != '0) && (rem_q >= divisor)) begin
        rem_d = rem_q - divisor;
        quo_d = quo_q + CNT_W'(1);
      end else begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/edge_train_generator.sv
// Emits N evenly spaced rising edges per UPDATE_PERIOD window from a BCD target.
// Optional EDGE_GEN_MONITOR_EN adds an edges_sent counter port and a window-end check.
module edge_train_generator
  import freq_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic       signal,
  output logic       window_start,
  output logic       busy
`ifdef EDGE_GEN_MONITOR_EN
  ,
  output logic [6:0] edges_sent
`endif
);

  localparam int unsigned SUM_W = N_W + 1;
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(UPDATE_PERIOD - 1);

  state_e             state_q, state_d;
  logic               pend_valid_q, pend_valid_d;
  logic [DIGIT_W-1:0] pend_ten_q, pend_ten_d;
  logic [DIGIT_W-1:0] pend_unit_q, pend_unit_d;
  logic [DIGIT_W-1:0] tcnt_q, tcnt_d;
  logic [DIGIT_W-1:0] units_q, units_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   p_q, p_d;
  logic [N_W-1:0]     k_q, k_d;
  logic               div_run_q, div_run_d;
  logic               signal_q, signal_d;
  logic               window_start_q, window_start_d;
  logic               busy_q, busy_d;

  logic               div_start_c;
  logic               div_done;
  logic [CNT_W-1:0]   div_quo;
  logic               take_c;
  logic [DIGIT_W-1:0] cap_ten_c, cap_unit_c;
  logic [SUM_W-1:0]   n_sum_c;
  logic [CNT_W-1:0]   half_c;

  rep_sub_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_c),
    .dividend (CNT_W'(UPDATE_PERIOD)),
    .divisor  (CNT_W'(n_q)),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pend_valid_q   <= 1'b0;
      pend_ten_q     <= '0;
      pend_unit_q    <= '0;
      tcnt_q         <= '0;
      units_q        <= '0;
      n_q            <= '0;
      s_q            <= '0;
      h_q            <= '0;
      w_q            <= '0;
      p_q            <= '0;
      k_q            <= '0;
      div_run_q      <= 1'b0;
      signal_q       <= 1'b0;
      window_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_ten_q     <= pend_ten_d;
      pend_unit_q    <= pend_unit_d;
      tcnt_q         <= tcnt_d;
      units_q        <= units_d;
      n_q            <= n_d;
      s_q            <= s_d;
      h_q            <= h_d;
      w_q            <= w_d;
      p_q            <= p_d;
      k_q            <= k_d;
      div_run_q      <= div_run_d;
      signal_q       <= signal_d;
      window_start_q <= window_start_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pend_valid_d   = pend_valid_q;
    pend_ten_d     = pend_ten_q;
    pend_unit_d    = pend_unit_q;
    tcnt_d         = tcnt_q;
    units_d        = units_q;
    n_d            = n_q;
    s_d            = s_q;
    h_d            = h_q;
    w_d            = w_q;
    p_d            = p_q;
    k_d            = k_q;
    div_run_d      = div_run_q;
    signal_d       = 1'b0;
    window_start_d = 1'b0;
    div_start_c    = 1'b0;
    take_c         = 1'b0;
    // A load in the capture cycle bypasses the pending registers.
    cap_ten_c      = load ? sat_digit(ten_count) : pend_ten_q;
    cap_unit_c     = load ? sat_digit(unit_count) : pend_unit_q;
    n_sum_c        = SUM_W'(n_q) + SUM_W'(units_q);
    half_c         = div_quo >> 1;

    if (load) begin
      pend_valid_d = 1'b1;
      pend_ten_d   = sat_digit(ten_count);
      pend_unit_d  = sat_digit(unit_count);
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q) take_c = 1'b1;
      end
      CONVERT: begin
        if (tcnt_q != '0) begin
          n_d    = n_q + N_W'(10);
          tcnt_d = tcnt_q - DIGIT_W'(1);
        end else begin
          n_d     = (n_sum_c > SUM_W'(MAX_COUNT)) ? N_W'(MAX_COUNT) : N_W'(n_sum_c);
          state_d = CALC;
        end
      end
      CALC: begin
        if (n_q == '0) begin
          s_d     = '0;
          h_d     = '0;
          w_d     = '0;
          p_d     = '0;
          k_d     = '0;
          state_d = RUN;
        end else if (!div_run_q) begin
          div_start_c = 1'b1;
          div_run_d   = 1'b1;
        end else if (div_done) begin
          div_run_d = 1'b0;
          s_d       = div_quo;
          h_d       = (half_c == '0) ? CNT_W'(1) : half_c;
          w_d       = '0;
          p_d       = '0;
          k_d       = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        window_start_d = (w_q == '0);
        signal_d       = (p_q < h_q) && (k_q < n_q);
        if (w_q == W_LAST) begin
          if (pend_valid_q || load) begin
            take_c = 1'b1;
          end else begin
            w_d = '0;
            p_d = '0;
            k_d = '0;
          end
        end else begin
          w_d = w_q + CNT_W'(1);
          // p tracks w mod S; k counts completed spacing periods, capped at N.
          if ((p_q + CNT_W'(1)) >= s_q) begin
            p_d = '0;
            if (k_q < n_q) k_d = k_q + N_W'(1);
          end else begin
            p_d = p_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_c) begin
      state_d      = CONVERT;
      tcnt_d       = cap_ten_c;
      units_d      = cap_unit_c;
      n_d          = '0;
      pend_valid_d = 1'b0;
      signal_d     = 1'b0;
    end

    busy_d = (state_d == CONVERT) || (state_d == CALC);
  end

  assign signal       = signal_q;
  assign window_start = window_start_q;
  assign busy         = busy_q;

`ifdef EDGE_GEN_MONITOR_EN
  logic [N_W-1:0] edges_q, edges_d;

  always_comb begin
    edges_d = edges_q;
    if ((state_q == RUN) && (w_q == '0)) begin
      edges_d = signal_d ? N_W'(1) : N_W'(0);
    end else if (signal_d && !signal_q && (edges_q < N_W'(MAX_COUNT))) begin
      edges_d = edges_q + N_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) edges_q <= '0;
    else       edges_q <= edges_d;
  end

  // Every edge of the window has been counted by its last cycle.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == RUN) && (w_q == W_LAST)) begin
      assert (edges_q == n_q);
    end
  end

  assign edges_sent = edges_q;
`endif

endmodule

// File: tb/tb_edge_train_generator.sv
// Scoreboard bench for edge_train_generator: loads are queued with their target N,
// a negedge monitor reconstructs each window and checks it against the arithmetic model.
module tb_edge_train_generator;

  localparam int UPD = 1200;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       signal;
  logic       window_start;
  logic       busy;
`ifdef EDGE_GEN_MONITOR_EN
  logic [6:0] edges_sent;
`endif

  edge_train_generator dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .ten_count    (ten_count),
    .unit_count   (unit_count),
    .signal       (signal),
    .window_start (window_start),
    .busy         (busy)
`ifdef EDGE_GEN_MONITOR_EN
    ,
    .edges_sent   (edges_sent)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at_edge;
    int n;
  } load_t;

  load_t load_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   win_cnt = 0;
  int   last_e0 = 0;
  int   cur_n = 0;
  int   exp_s = 1;
  int   exp_h = 1;
  int   j = 0;
  bit   in_win = 0;
  bit   idle_mode = 1;
  bit   rst_prev = 0;
  logic sig_buf [0:UPD-1];
  int   es_rec = 0;

  function automatic int bcd_target(input int t, input int u);
    return ((t > 9) ? 9 : t) * 10 + ((u > 9) ? 9 : u);
  endfunction

  task automatic finalize_window();
    int   mism;
    int   first_bad;
    int   edges;
    logic prev;
    logic e;
    mism = 0; first_bad = -1; edges = 0; prev = 1'b0;
    for (int i = 0; i < UPD; i++) begin
      e = (cur_n > 0) && (i < cur_n * exp_s) && ((i % exp_s) < exp_h);
      if (sig_buf[i] !== e) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
      if (sig_buf[i] === 1'b1 && prev === 1'b0) edges++;
      prev = sig_buf[i];
    end
    n_cmp++;
    if (mism != 0) begin
      n_err++;
      $display("FAIL window_waveform N=%0d S=%0d H=%0d: %0d wrong samples (first at w=%0d), required 0",
               cur_n, exp_s, exp_h, mism, first_bad);
    end
    n_cmp++;
    if (edges != cur_n) begin
      n_err++;
      $display("FAIL window_edges: got %0d rising edges, required %0d", edges, cur_n);
    end
`ifdef EDGE_GEN_MONITOR_EN
    n_cmp++;
    if (es_rec != cur_n) begin
      n_err++;
      $display("FAIL edges_sent: got %0d at window end, required %0d", es_rec, cur_n);
    end
`endif
  endtask

  task automatic start_window();
    int bnd;
    bit changed;
    changed = 0;
    if (idle_mode) begin
      n_cmp++;
      if (load_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_window: window_start at cycle %0d with no target loaded, required none", cyc);
        bnd = -1;
      end else begin
        bnd = load_q[0].at_edge + 1;
      end
    end else begin
      bnd = last_e0 + UPD - 1;
    end
    while (load_q.size() > 0 && load_q[0].at_edge <= bnd) begin
      cur_n = load_q[0].n;
      void'(load_q.pop_front());
      changed = 1;
    end
    if (!idle_mode) begin
      n_cmp++;
      if (changed ? (cyc - last_e0 <= UPD) : (cyc - last_e0 != UPD)) begin
        n_err++;
        $display("FAIL window_spacing: got %0d cycles, required %s", cyc - last_e0,
                 changed ? "more than 1200" : "exactly 1200");
      end
    end
    idle_mode = 0;
    exp_s = (cur_n > 0) ? UPD / cur_n : 1;
    exp_h = (exp_s / 2 < 1) ? 1 : exp_s / 2;
    last_e0 = cyc;
    sig_buf[0] = signal;
    j = 1;
    in_win = 1;
    win_cnt++;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rst_prev) begin
        n_cmp++;
        if (signal !== 1'b0 || window_start !== 1'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL reset_outputs: signal=%0b window_start=%0b busy=%0b, required all 0",
                   signal, window_start, busy);
        end
      end
      rst_prev  = 1;
      in_win    = 0;
      idle_mode = 1;
      load_q.delete();
    end else begin
      rst_prev = 0;
      if (in_win && j == UPD) begin
        finalize_window();
        in_win = 0;
      end
      if (window_start === 1'b1) begin
        start_window();
      end else if (in_win) begin
        sig_buf[j] = signal;
`ifdef EDGE_GEN_MONITOR_EN
        if (j == UPD - 2) es_rec = int'(edges_sent);
`endif
        j++;
      end else begin
        n_cmp++;
        if (signal !== 1'b0) begin
          n_err++;
          $display("FAIL gap_signal: signal=%0b outside a window at cycle %0d, required 0", signal, cyc);
        end
        if (idle_mode && load_q.size() == 0) begin
          n_cmp++;
          if (window_start !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_outputs: window_start=%0b busy=%0b, required 0 0", window_start, busy);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int t, input int u);
    load       = 1'b1;
    ten_count  = 4'(t);
    unit_count = 4'(u);
    load_q.push_back('{at_edge: cyc + 1, n: bcd_target(t, u)});
    step();
    load = 1'b0;
  endtask

  task automatic wait_windows(input int n);
    int target;
    int t;
    target = win_cnt + n;
    t = 0;
    while (win_cnt < target && t < 3000 * n) begin
      step();
      t++;
    end
    n_cmp++;
    if (win_cnt < target) begin
      n_err++;
      $display("FAIL window_timeout: saw %0d windows, required %0d", win_cnt, target);
    end
  endtask

  // Positions the driver so the next load is sampled at the end of window cycle w=off.
  task automatic goto_offset(input int off);
    wait_windows(1);
    while (cyc < last_e0 + off - 1) step();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; ten_count = '0; unit_count = '0;
    repeat (3) step();
    reset = 1'b0;

    repeat (3000) step();

    do_load(2, 3);
    wait_windows(4);

    do_load(9, 9);
    wait_windows(3);

    goto_offset(600);
    do_load(0, 0);
    wait_windows(3);

    goto_offset(200);
    do_load(0, 5);
    while (cyc < last_e0 + 699) step();
    do_load(4, 0);
    wait_windows(2);

    goto_offset(1199);
    do_load(1, 2);
    wait_windows(2);

    begin
      int t;
      goto_offset(100);
      do_load(3, 3);
      t = 0;
      while (busy !== 1'b1 && t < 3000) begin
        step();
        t++;
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_timeout: busy=%0b, required 1", busy);
      end
      do_load(6, 1);
      wait_windows(3);
    end

    do_load(5, 0);
    goto_offset(600);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (200) step();
    do_load(1, 0);
    wait_windows(2);

    for (int r = 0; r < 6; r++) begin
      int off;
      off = int'($urandom_range(3, 1199));
      goto_offset(off);
      do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1 && off < 1100) begin
        while (cyc < last_e0 + off + 50) step();
        do_load(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      wait_windows(1);
    end

    wait_windows(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL global_timeout: bench did not finish within 95000 cycles, required completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
